// File: rtl/max8.sv
// max8: peak-magnitude detector for a signed sample stream.
// Takes |sig| each clock and holds the largest magnitude seen since reset.
// Optional feature: define MAX8_DECAY_EN to let the held peak decay by one
// every 2^DECAY_SHIFT clocks without a new peak.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset, clears the held peak
//   sig  - WIDTH-bit two's-complement sample, valid every clock
//   max  - WIDTH-1 bit unsigned peak magnitude, driven from a flop
module max8 #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DECAY_SHIFT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-2:0] max
);

  localparam int unsigned MAG_W = WIDTH - 1;

  logic [WIDTH-1:0] neg_c;
  logic [MAG_W-1:0] mag_c;
  logic             new_peak_c;
  logic [MAG_W-1:0] max_d, max_q;

  // Absolute value; the most-negative input negates to itself, so saturate it.
  always_comb begin
    neg_c = ~sig + WIDTH'(1);
    if (sig[WIDTH-1]) begin
      mag_c = neg_c[WIDTH-1] ? {MAG_W{1'b1}} : neg_c[MAG_W-1:0];
    end else begin
      mag_c = sig[MAG_W-1:0];
    end
  end

  assign new_peak_c = (mag_c > max_q);

`ifdef MAX8_DECAY_EN
  logic [DECAY_SHIFT-1:0] cnt_d, cnt_q;
  logic                   wrap_c;

  assign wrap_c = (cnt_q == {DECAY_SHIFT{1'b1}});

  // New peak wins over decay and restarts the decay interval.
  always_comb begin
    max_d = max_q;
    cnt_d = cnt_q + DECAY_SHIFT'(1);
    if (new_peak_c) begin
      max_d = mag_c;
      cnt_d = '0;
    end else if (wrap_c && (max_q != '0)) begin
      max_d = max_q - MAG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Pure peak-hold.
  always_comb begin
    max_d = max_q;
    if (new_peak_c) begin
      max_d = mag_c;
    end
  end
`endif

  // Held peak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max = max_q;

endmodule

// File: tb/tb_max8.sv
module tb_max8;

  logic       clk;
  logic       rst;
  logic [7:0] sig;
  logic [6:0] max;

  int checks = 0;
  int errors = 0;
  int model_max = 0;
  int cur = 0;
  int exp_q[$];

  max8 dut (
    .clk(clk),
    .rst(rst),
    .sig(sig),
    .max(max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mag_of(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 127) m = 127;
    return m;
  endfunction

  task automatic check(input string tag, input int expv);
    checks++;
    assert (max === 7'(expv)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, max, expv);
    end
  endtask

  // Drive one sample at negedge, push the model's expectation, compare after the edge.
  task automatic step(input int v);
    int e;
    @(negedge clk);
    sig = 8'(v);
    if (mag_of(v) > model_max) model_max = mag_of(v);
    exp_q.push_back(model_max);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      check($sformatf("step sig=%0d", v), e);
    end
  endtask

  task automatic ramp_to(input int target);
    while (cur != target) begin
      cur = (target > cur) ? cur + 1 : cur - 1;
      step(cur);
    end
  endtask

  initial begin
    rst = 1'b1;
    sig = 8'h00;
    #2;
    check("reset_initial", 0);
    @(negedge clk);
    rst = 1'b0;

    cur = 0;
    step(0);
    step(0);
    ramp_to(8);
    ramp_to(-16);
    ramp_to(24);
    ramp_to(-32);
    ramp_to(0);
    check("hold_32", 32);

    // Asynchronous reset mid-stream: output clears before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    model_max = 0;
    exp_q.delete();
    #1;
    check("async_reset", 0);
    @(posedge clk);
    #1;
    check("reset_held", 0);
    @(negedge clk);
    rst = 1'b0;
    step(0);
    step(0);
    step(5);

    // Edge values.
    step(-128);
    step(127);
    step(-127);
    step(-1);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
